irq_sequencer: RTL and testbench
================================

# irq_sequencer

Interrupt controller for the CPU. Latches up to N_IRQ edge-triggered requests, selects one by fixed priority, and sequences the context-save register: a save-enable pulse captures carry, zero and PC. It then forces a PC load to the selected vector, waits for return-from-interrupt, and restores context. It sits between the peripheral request lines, the control unit and the context-save register. There is no nesting: one interrupt is serviced at a time.

## Interface
- N_IRQ, 4: number of request lines (1..8).
- VEC_BASE, 12'h010: vector address of line 0.
- VEC_STRIDE, 12'h004: vector spacing per line.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  state advances only when high; rst acts regardless.
- irq_i  in  N_IRQ  request lines; a rising edge marks a line pending.
- mask_we_i  in  1  writes mask_i into the mask register.
- mask_i  in  N_IRQ  enable bit per line (1 = enabled).
- gie_set_i  in  1  sets the global interrupt enable.
- gie_clr_i  in  1  clears the global interrupt enable.
- boundary_i  in  1  control unit is at an instruction boundary; entry is allowed.
- reti_i  in  1  return-from-interrupt executed.
- save_o  out  1  one-cycle pulse; drives wrt_en of the context-save register.
- pc_load_o  out  1  one-cycle pulse; the PC loads vector_o.
- vector_o  out  12  vector address.
- restore_o  out  1  one-cycle pulse; the PC, C and Z reload from the saved context.
- ack_o  out  N_IRQ  one-hot acknowledge, asserted in the SAVE cycle.
- busy_o  out  1  high in every state except IDLE.
- active_id_o  out  3  index of the line being serviced.
- pending_o  out  N_IRQ  pending register.

## Operation
- Edge detection:
  - irq_prev is registered each enabled cycle.
  - An edge on line i is `irq_i[i] & ~irq_prev[i]`; it sets pending[i].
- Pending clear: pending[i] clears in the SAVE cycle for the line being acked.
  - If a new edge on the same line arrives in that cycle, the set wins.
- Masked lines still latch pending; they only become eligible when the mask bit is set.
- GIE:
  - gie_set_i and gie_clr_i in the same cycle: clear wins.
  - GIE is cleared on entry; the pre-entry value is held in gie_saved.
- eligible = pending & mask. The winner is the lowest index among eligible lines.
- FSM states:
  - IDLE: go to SAVE when gie, eligible != 0 and boundary_i are all high. The winner is latched into active_id.
  - SAVE: save_o=1, ack_o[active_id]=1, pending bit cleared, gie cleared. Go to VECTOR.
  - VECTOR: pc_load_o=1. Go to SERVICE.
  - SERVICE: wait for reti_i, then go to RESTORE.
    - New requests keep latching pending.
    - gie_set_i and gie_clr_i update gie normally.
  - RESTORE: restore_o=1, gie is loaded from gie_saved. Go to IDLE.
- vector_o = VEC_BASE + active_id*VEC_STRIDE, truncated to 12 bits (wraps modulo 4096).
  - vector_o is registered and held stable from VECTOR through the end of SERVICE.
- reti_i outside SERVICE is ignored.
- Inputs are ignored while clk_en is low: no state change and no edge detection. Output pulses hold their current level.

## Timing
- Reset values:
  - state IDLE; pending, mask, irq_prev = 0; gie = 0; gie_saved = 0.
  - save_o, pc_load_o, restore_o, ack_o, busy_o = 0; active_id_o = 0.
  - vector_o = VEC_BASE.
- rst asserted in any state returns to IDLE on the next edge, with no pulses issued.
- Latencies, with clk_en held high:
  - An edge at cycle t makes pending visible at t+1.
  - The earliest SAVE is t+2 (requires boundary_i high at t+1).
  - VECTOR is at t+3; SERVICE begins at t+4.
- Pulse sequence: save_o, then pc_load_o one cycle later. Never both in the same cycle.
- reti_i at cycle r gives restore_o at r+1 and IDLE at r+2.
  - A new entry is possible at r+2 if something is eligible; re-entry needs boundary_i high in IDLE.
- busy_o is registered and high in SAVE, VECTOR, SERVICE and RESTORE.

## Test plan
- Basic entry and return:
  - Stimulus: reset; mask=4'b1111; gie_set; boundary_i held high; edge on irq_i[2].
  - Required: ack_o=4'b0100, then a save_o pulse, then a pc_load_o pulse with vector_o=12'h018.
  - Required: on reti_i, a restore_o pulse; gie=1 and pending=0 afterwards.
- Priority:
  - Stimulus: edges on lines 1 and 3 in the same cycle.
  - Required: line 1 is serviced first (vector 12'h014); line 3 is serviced after reti (vector 12'h01C).
- Masking:
  - Stimulus: mask=4'b0111; edge on line 3.
  - Required: pending_o[3]=1 and no entry.
  - Stimulus: then write mask=4'b1111.
  - Required: entry with vector 12'h01C.
- GIE and boundary gating:
  - Stimulus: gie=0 with a pending line.
  - Required: no entry.
  - Stimulus: gie_set and gie_clr in the same cycle.
  - Required: gie stays 0.
  - Stimulus: gie=1 with boundary_i=0.
  - Required: entry waits until boundary_i=1.
- Ack collision and clk_en stall:
  - Stimulus: a new edge on the acked line during SAVE.
  - Required: pending stays 1.
  - Stimulus: clk_en low for 3 cycles in VECTOR.
  - Required: pc_load_o is held and the state is unchanged.
- Reset in SERVICE:
  - Stimulus: assert rst during SERVICE.
  - Required: state IDLE, all outputs at reset values, and no restore_o pulse.

Source files
------------

// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer: latches request edges, picks the lowest
// eligible line, and pulses save / PC-load / restore around a single service.
module irq_sequencer #(
  parameter int unsigned N_IRQ      = 4,
  parameter logic [11:0] VEC_BASE   = 12'h010,
  parameter logic [11:0] VEC_STRIDE = 12'h004
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_i,
  input  logic             gie_set_i,
  input  logic             gie_clr_i,
  input  logic             boundary_i,
  input  logic             reti_i,
  output logic             save_o,
  output logic             pc_load_o,
  output logic [11:0]      vector_o,
  output logic             restore_o,
  output logic [N_IRQ-1:0] ack_o,
  output logic             busy_o,
  output logic [2:0]       active_id_o,
  output logic [N_IRQ-1:0] pending_o
);

  localparam int unsigned IDW = 3;
  localparam int unsigned VW  = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_VECTOR,
    S_SERVICE,
    S_RESTORE
  } state_t;

  state_t           state, state_next;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] mask;
  logic             gie, gie_next;
  logic             gie_saved, gie_saved_next;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] pending_next;
  logic [IDW-1:0]   win_id;
  logic             save_next, pc_load_next, restore_next, busy_next;
  logic [N_IRQ-1:0] ack_next;
  logic [IDW-1:0]   active_id_next;
  logic [VW-1:0]    vector_next;

  // Next-state, context sequencing and registered-output values
  always_comb begin
    rise           = irq_i & ~irq_prev;
    eligible       = pending_o & mask;
    win_id         = '0;
    state_next     = state;
    clr            = '0;
    save_next      = 1'b0;
    pc_load_next   = 1'b0;
    restore_next   = 1'b0;
    ack_next       = '0;
    active_id_next = active_id_o;
    vector_next    = vector_o;
    gie_saved_next = gie_saved;
    gie_next       = gie;

    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = IDW'(i);
    end

    if (gie_clr_i)      gie_next = 1'b0;
    else if (gie_set_i) gie_next = 1'b1;

    case (state)
      S_IDLE: begin
        if (gie && (|eligible) && boundary_i) begin
          state_next     = S_SAVE;
          save_next      = 1'b1;
          ack_next       = N_IRQ'(1) << win_id;
          active_id_next = win_id;
          vector_next    = VW'(VEC_BASE + VW'(win_id) * VEC_STRIDE);
          gie_saved_next = gie;
        end
      end
      S_SAVE: begin
        clr          = N_IRQ'(1) << active_id_o;
        gie_next     = 1'b0;
        state_next   = S_VECTOR;
        pc_load_next = 1'b1;
      end
      S_VECTOR: state_next = S_SERVICE;
      S_SERVICE: begin
        if (reti_i) begin
          state_next   = S_RESTORE;
          restore_next = 1'b1;
        end
      end
      S_RESTORE: begin
        gie_next   = gie_saved;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // A fresh edge on the acked line outranks the clear
    pending_next = (pending_o & ~clr) | rise;
    busy_next    = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      irq_prev    <= '0;
      mask        <= '0;
      gie         <= 1'b0;
      gie_saved   <= 1'b0;
      pending_o   <= '0;
      save_o      <= 1'b0;
      pc_load_o   <= 1'b0;
      restore_o   <= 1'b0;
      ack_o       <= '0;
      busy_o      <= 1'b0;
      active_id_o <= '0;
      vector_o    <= VEC_BASE;
    end else if (clk_en) begin
      state       <= state_next;
      irq_prev    <= irq_i;
      if (mask_we_i) mask <= mask_i;
      gie         <= gie_next;
      gie_saved   <= gie_saved_next;
      pending_o   <= pending_next;
      save_o      <= save_next;
      pc_load_o   <= pc_load_next;
      restore_o   <= restore_next;
      ack_o       <= ack_next;
      busy_o      <= busy_next;
      active_id_o <= active_id_next;
      vector_o    <= vector_next;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed plus randomized bench for irq_sequencer; a cycle-level reference
// model derived from the interrupt rules predicts every output each cycle.
module tb_irq_sequencer;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_in;
  logic        gie_set;
  logic        gie_clr;
  logic        boundary;
  logic        reti;
  logic        save_o;
  logic        pc_load_o;
  logic [11:0] vector_o;
  logic        restore_o;
  logic [3:0]  ack_o;
  logic        busy_o;
  logic [2:0]  active_id_o;
  logic [3:0]  pending_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: phase counts position in the entry sequence
  // (0 idle, 1 save, 2 vector, 3 service, 4 restore).
  int          m_ph;
  int          m_id;
  logic [3:0]  m_pend, m_mask, m_prev;
  bit          m_gie, m_gsave;
  logic [11:0] m_vec;

  irq_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .irq_i      (irq),
    .mask_we_i  (mask_we),
    .mask_i     (mask_in),
    .gie_set_i  (gie_set),
    .gie_clr_i  (gie_clr),
    .boundary_i (boundary),
    .reti_i     (reti),
    .save_o     (save_o),
    .pc_load_o  (pc_load_o),
    .vector_o   (vector_o),
    .restore_o  (restore_o),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .active_id_o(active_id_o),
    .pending_o  (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    logic [3:0] rises;
    logic [3:0] elig;
    bit         g;
    if (rst) begin
      m_ph = 0; m_id = 0; m_pend = '0; m_mask = '0; m_prev = '0;
      m_gie = 1'b0; m_gsave = 1'b0; m_vec = 12'h010;
    end else if (clk_en) begin
      rises = irq & ~m_prev;
      elig  = m_pend & m_mask;
      g     = m_gie;
      if (gie_clr)      g = 1'b0;
      else if (gie_set) g = 1'b1;
      case (m_ph)
        0: if (m_gie && elig != 4'b0 && boundary) begin
             for (int i = 0; i < 4; i++) begin
               if (elig[i]) begin m_id = i; break; end
             end
             m_vec   = 12'(16 + 4 * m_id);
             m_gsave = m_gie;
             m_ph    = 1;
           end
        1: begin m_pend[m_id] = 1'b0; g = 1'b0; m_ph = 2; end
        2: m_ph = 3;
        3: if (reti) m_ph = 4;
        default: begin g = m_gsave; m_ph = 0; end
      endcase
      m_pend = m_pend | rises;
      m_gie  = g;
      m_prev = irq;
      if (mask_we) m_mask = mask_in;
    end
  endtask

  task automatic compare_all();
    check("save",      32'(save_o),      32'(m_ph == 1));
    check("pc_load",   32'(pc_load_o),   32'(m_ph == 2));
    check("restore",   32'(restore_o),   32'(m_ph == 4));
    check("busy",      32'(busy_o),      32'(m_ph != 0));
    check("ack",       32'(ack_o),       (m_ph == 1) ? (32'd1 << m_id) : 32'd0);
    check("active_id", 32'(active_id_o), 32'(m_id));
    check("vector",    32'(vector_o),    32'(m_vec));
    check("pending",   32'(pending_o),   32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0;
    gie_set = 1'b0; gie_clr = 1'b0; boundary = 1'b0; reti = 1'b0;
    m_ph = 0; m_id = 0; m_pend = '0; m_mask = '0; m_prev = '0;
    m_gie = 1'b0; m_gsave = 1'b0; m_vec = 12'h010;
    step(); step();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_vector", 32'(vector_o), 32'h010);
    check("rst_pending", 32'(pending_o), 32'd0);
    rst = 1'b0;

    // Basic entry and return on line 2
    mask_we = 1'b1; mask_in = 4'b1111; gie_set = 1'b1;
    step();
    mask_we = 1'b0; gie_set = 1'b0; boundary = 1'b1; irq = 4'b0100;
    step();
    check("basic_pending", 32'(pending_o), 32'h4);
    irq = '0;
    step();
    check("basic_ack", 32'(ack_o), 32'h4);
    check("basic_save", 32'(save_o), 32'd1);
    step();
    check("basic_pc_load", 32'(pc_load_o), 32'd1);
    check("basic_vector", 32'(vector_o), 32'h018);
    step(); step();
    reti = 1'b1; step();
    check("basic_restore", 32'(restore_o), 32'd1);
    reti = 1'b0; step();
    check("basic_idle", 32'(busy_o), 32'd0);
    check("basic_pend_clr", 32'(pending_o), 32'd0);

    // Priority: lines 1 and 3 together; gie restored by previous return
    irq = 4'b1010; step();
    irq = '0; step();
    check("prio_first_ack", 32'(ack_o), 32'h2);
    step();
    check("prio_first_vec", 32'(vector_o), 32'h014);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();
    step();
    check("prio_second_ack", 32'(ack_o), 32'h8);
    step();
    check("prio_second_vec", 32'(vector_o), 32'h01C);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Masking
    mask_we = 1'b1; mask_in = 4'b0111; step();
    mask_we = 1'b0; irq = 4'b1000; step();
    irq = '0;
    repeat (4) step();
    check("mask_no_entry", 32'(busy_o), 32'd0);
    check("mask_pending3", 32'(pending_o[3]), 32'd1);
    mask_we = 1'b1; mask_in = 4'b1111; step();
    mask_we = 1'b0; step();
    check("mask_entry", 32'(save_o), 32'd1);
    step();
    check("mask_vec", 32'(vector_o), 32'h01C);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // GIE and boundary gating
    gie_clr = 1'b1; step();
    gie_clr = 1'b0; irq = 4'b0001; step();
    irq = '0;
    repeat (3) step();
    check("gie0_no_entry", 32'(busy_o), 32'd0);
    gie_set = 1'b1; gie_clr = 1'b1; step();
    gie_set = 1'b0; gie_clr = 1'b0;
    repeat (2) step();
    check("gie_clr_wins", 32'(busy_o), 32'd0);
    boundary = 1'b0; gie_set = 1'b1; step();
    gie_set = 1'b0;
    repeat (3) step();
    check("boundary_wait", 32'(busy_o), 32'd0);
    boundary = 1'b1; step();
    check("boundary_entry", 32'(save_o), 32'd1);
    check("boundary_ack", 32'(ack_o), 32'h1);

    // Ack collision, then clk_en stall in VECTOR
    irq = 4'b0001; step();
    check("collide_pending", 32'(pending_o[0]), 32'd1);
    clk_en = 1'b0; mask_we = 1'b1; mask_in = 4'b0000;
    repeat (3) begin
      step();
      check("stall_pc_load", 32'(pc_load_o), 32'd1);
      check("stall_save", 32'(save_o), 32'd0);
    end
    clk_en = 1'b1; mask_we = 1'b0; step();
    check("stall_resume", 32'(pc_load_o), 32'd0);
    reti = 1'b1; step();
    reti = 1'b0; step();
    step();
    check("reentry_save", 32'(save_o), 32'd1);

    // Reset during SERVICE
    step(); step();
    rst = 1'b1; reti = 1'b1; step();
    check("svc_rst_busy", 32'(busy_o), 32'd0);
    check("svc_rst_restore", 32'(restore_o), 32'd0);
    check("svc_rst_vector", 32'(vector_o), 32'h010);
    check("svc_rst_pending", 32'(pending_o), 32'd0);
    rst = 1'b0; reti = 1'b0; irq = '0; step();
    check("svc_rst_no_restore", 32'(restore_o), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      mask_we  = ($urandom_range(0, 19) == 0);
      mask_in  = 4'($urandom);
      gie_set  = ($urandom_range(0, 9) == 0);
      gie_clr  = ($urandom_range(0, 29) == 0);
      boundary = ($urandom_range(0, 3) != 0);
      reti     = ($urandom_range(0, 4) == 0);
      clk_en   = ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
